// File: rtl/csr_counter_access.sv
// csr_counter_access: executes Zicsr read-modify-write on the 64-bit cycle/instret counters.
// Sequencer IDLE -> EXEC -> RESP: latch the request, sample the live counter and compute, then emit a one-cycle response.
module csr_counter_access #(
  parameter int COUNT_LEN = 64,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 csr_req,
  input  logic [11:0]          csr_addr,
  input  logic [1:0]           csr_op,
  input  logic [XLEN-1:0]      csr_wdata,
  input  logic                 csr_wr_en,
  input  logic [COUNT_LEN-1:0] cycle_in,
  input  logic [COUNT_LEN-1:0] instret_in,
  output logic                 busy,
  output logic                 csr_done,
  output logic [XLEN-1:0]      csr_rdata,
  output logic                 csr_illegal,
  output logic                 cycle_wr,
  output logic [COUNT_LEN-1:0] cycle_wr_data,
  output logic                 instret_wr,
  output logic [COUNT_LEN-1:0] instret_wr_data
);

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  logic [11:0]     addr_p0;
  logic [1:0]      op_p0;
  logic [XLEN-1:0] wdata_p0;
  logic            wr_en_p0;

  logic                 sel_hi_p0;
  logic                 sel_instret_p0;
  logic                 ro_p0;
  logic                 wr_req_p0;
  logic                 illegal_p0;
  logic                 do_wr_p0;
  logic [COUNT_LEN-1:0] live_p0;
  logic [COUNT_LEN-1:0] wr_word_p0;
  logic [XLEN-1:0]      old_p0;
  logic [XLEN-1:0]      new_p0;

  function automatic logic addr_known(input logic [11:0] a);
    case (a)
      12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: addr_known = 1'b1;
      default:                            addr_known = 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] apply_op(input logic [1:0]      op,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] wd);
    case (op)
      OP_RW:   apply_op = wd;
      OP_RS:   apply_op = old | wd;
      OP_RC:   apply_op = old & ~wd;
      default: apply_op = old;
    endcase
  endfunction

  // Stage p0: request operands, captured only on acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && csr_req) begin
      addr_p0  <= csr_addr;
      op_p0    <= csr_op;
      wdata_p0 <= csr_wdata;
      wr_en_p0 <= csr_wr_en;
    end
  end

  // EXEC: address bit 7 picks the high half, bit 1 picks instret, 0xCxx marks the user shadows
  always_comb begin
    sel_hi_p0      = addr_p0[7];
    sel_instret_p0 = addr_p0[1];
    ro_p0          = (addr_p0[11:8] == 4'hC);
    live_p0        = sel_instret_p0 ? instret_in : cycle_in;
    old_p0         = sel_hi_p0 ? live_p0[COUNT_LEN-1:XLEN] : live_p0[XLEN-1:0];
    new_p0         = apply_op(op_p0, old_p0, wdata_p0);
    wr_req_p0      = (op_p0 == OP_RW) || wr_en_p0;
    illegal_p0     = (op_p0 == 2'b00) || !addr_known(addr_p0) || (ro_p0 && wr_req_p0);
    do_wr_p0       = !illegal_p0 && !ro_p0 && wr_req_p0;
    wr_word_p0     = sel_hi_p0 ? {new_p0, live_p0[XLEN-1:0]}
                               : {live_p0[COUNT_LEN-1:XLEN], new_p0};
  end

  // Stage p1: registered response, visible for exactly the RESP cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      csr_done        <= 1'b0;
      csr_rdata       <= '0;
      csr_illegal     <= 1'b0;
      cycle_wr        <= 1'b0;
      cycle_wr_data   <= '0;
      instret_wr      <= 1'b0;
      instret_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          csr_done    <= 1'b0;
          csr_illegal <= 1'b0;
          cycle_wr    <= 1'b0;
          instret_wr  <= 1'b0;
          if (csr_req) begin
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          csr_done    <= 1'b1;
          csr_illegal <= illegal_p0;
          csr_rdata   <= illegal_p0 ? '0 : old_p0;
          cycle_wr    <= do_wr_p0 && !sel_instret_p0;
          instret_wr  <= do_wr_p0 && sel_instret_p0;
          if (do_wr_p0 && !sel_instret_p0) cycle_wr_data <= wr_word_p0;
          if (do_wr_p0 && sel_instret_p0)  instret_wr_data <= wr_word_p0;
          state <= RESP;
        end
        RESP: begin
          busy        <= 1'b0;
          csr_done    <= 1'b0;
          csr_illegal <= 1'b0;
          cycle_wr    <= 1'b0;
          instret_wr  <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_counter_access.sv
// Directed plus randomized bench for csr_counter_access with a response scoreboard.
module tb_csr_counter_access;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ill;
    logic        cwr;
    logic        iwr;
    logic [63:0] wd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_req;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        csr_wr_en;
  logic [63:0] cycle_in;
  logic [63:0] instret_in;
  logic        busy;
  logic        csr_done;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        cycle_wr;
  logic [63:0] cycle_wr_data;
  logic        instret_wr;
  logic [63:0] instret_wr_data;

  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  csr_counter_access #(.COUNT_LEN(64), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .csr_req(csr_req), .csr_addr(csr_addr),
    .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_wr_en(csr_wr_en),
    .cycle_in(cycle_in), .instret_in(instret_in), .busy(busy),
    .csr_done(csr_done), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .cycle_wr(cycle_wr), .cycle_wr_data(cycle_wr_data),
    .instret_wr(instret_wr), .instret_wr_data(instret_wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic i, input logic c,
                              input logic n, input logic [63:0] w);
    exp_t e;
    e.rdata = r; e.ill = i; e.cwr = c; e.iwr = n; e.wd = w;
    return e;
  endfunction

  function automatic exp_t model(input logic [11:0] a, input logic [1:0] op,
                                 input logic [31:0] wd, input logic we,
                                 input logic [63:0] cyc, input logic [63:0] ins);
    exp_t e;
    logic [63:0] v;
    logic [31:0] old, nv;
    logic hi, ro, known, tgt_ins, writes, dowr;
    v = cyc; hi = 1'b0; ro = 1'b0; known = 1'b1; tgt_ins = 1'b0;
    case (a)
      12'hB00: v = cyc;
      12'hB80: begin v = cyc; hi = 1'b1; end
      12'hB02: begin v = ins; tgt_ins = 1'b1; end
      12'hB82: begin v = ins; hi = 1'b1; tgt_ins = 1'b1; end
      12'hC00: ro = 1'b1;
      12'hC80: begin ro = 1'b1; hi = 1'b1; end
      12'hC02: begin ro = 1'b1; v = ins; end
      12'hC82: begin ro = 1'b1; v = ins; hi = 1'b1; end
      default: known = 1'b0;
    endcase
    old = hi ? v[63:32] : v[31:0];
    case (op)
      2'b01:   nv = wd;
      2'b10:   nv = old | wd;
      2'b11:   nv = old & ~wd;
      default: nv = old;
    endcase
    writes  = (op == 2'b01) || we;
    e.ill   = (op == 2'b00) || !known || (ro && writes);
    e.rdata = e.ill ? 32'h0 : old;
    dowr    = !e.ill && !ro && writes;
    e.cwr   = dowr && !tgt_ins;
    e.iwr   = dowr && tgt_ins;
    e.wd    = hi ? {nv, v[31:0]} : {v[63:32], nv};
    return e;
  endfunction

  // Response monitor: pops one expectation per done strobe
  always @(negedge clk) begin
    if (mon_en && csr_done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(csr_done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rdata", 64'(csr_rdata), 64'(e.rdata));
        chk("illegal", 64'(csr_illegal), 64'(e.ill));
        chk("cycle_wr", 64'(cycle_wr), 64'(e.cwr));
        chk("instret_wr", 64'(instret_wr), 64'(e.iwr));
        if (e.cwr) chk("cycle_wr_data", cycle_wr_data, e.wd);
        if (e.iwr) chk("instret_wr_data", instret_wr_data, e.wd);
      end
    end else if (mon_en && (cycle_wr || instret_wr)) begin
      chk("strobe_without_done", 64'({cycle_wr, instret_wr}), 64'd0);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(csr_done), 64'd0);
    chk({tag, "_illegal"}, 64'(csr_illegal), 64'd0);
    chk({tag, "_strobes"}, 64'({cycle_wr, instret_wr}), 64'd0);
    chk({tag, "_rdata"}, 64'(csr_rdata), 64'd0);
    chk({tag, "_cwd"}, cycle_wr_data, 64'd0);
    chk({tag, "_iwd"}, instret_wr_data, 64'd0);
  endtask

  task automatic run(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                     input logic we, input exp_t e, input bit hold);
    csr_addr = a; csr_op = op; csr_wdata = wd; csr_wr_en = we; csr_req = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    if (!hold) csr_req = 1'b0;
    @(negedge clk);
    chk("busy_exec", 64'(busy), 64'd1);
    chk("done_exec", 64'(csr_done), 64'd0);
    csr_req = 1'b0;
    @(negedge clk);
    chk("busy_resp", 64'(busy), 64'd1);
    chk("done_resp", 64'(csr_done), 64'd1);
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("done_after", 64'(csr_done), 64'd0);
    chk("strobes_after", 64'({cycle_wr, instret_wr}), 64'd0);
  endtask

  initial begin
    logic [11:0] addrs [10];
    logic [11:0] ra;
    logic [1:0]  rop;
    logic [31:0] rwd;
    logic        rwe;
    addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
              12'hC80, 12'hC02, 12'hC82, 12'h123, 12'hB01};
    rst_n = 1'b0; csr_req = 1'b0; csr_addr = '0; csr_op = '0;
    csr_wdata = '0; csr_wr_en = 1'b0; cycle_in = '0; instret_in = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    cycle_in = 64'h0000_0001_FFFF_FFF0;
    run(12'hC00, 2'b10, 32'h0, 1'b0, mk(32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 64'h0), 1'b0);
    instret_in = 64'h0000_0002_0000_0010;
    run(12'hB82, 2'b01, 32'h5, 1'b1, mk(32'h2, 1'b0, 1'b0, 1'b1, 64'h0000_0005_0000_0010), 1'b0);
    cycle_in = 64'h0000_0007_0000_000F;
    run(12'hB00, 2'b10, 32'hF0, 1'b1, mk(32'h0F, 1'b0, 1'b1, 1'b0, 64'h0000_0007_0000_00FF), 1'b0);
    cycle_in = 64'h0000_0007_0000_00FF;
    run(12'hB00, 2'b11, 32'h0F, 1'b1, mk(32'hFF, 1'b0, 1'b1, 1'b0, 64'h0000_0007_0000_00F0), 1'b0);
    run(12'hC02, 2'b01, 32'h1, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b0, 64'h0), 1'b0);
    run(12'hB00, 2'b00, 32'h1, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b0, 64'h0), 1'b0);
    run(12'h123, 2'b10, 32'h0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b0, 64'h0), 1'b0);

    cycle_in = 64'h0000_0007_0000_00F0;
    run(12'hB80, 2'b01, 32'hAA, 1'b1, mk(32'h7, 1'b0, 1'b1, 1'b0, 64'h0000_00AA_0000_00F0), 1'b1);
    run(12'hB02, 2'b10, 32'h0, 1'b0, mk(32'h10, 1'b0, 1'b0, 1'b0, 64'h0), 1'b0);
    run(12'hC82, 2'b11, 32'hFFFF, 1'b0, mk(32'h2, 1'b0, 1'b0, 1'b0, 64'h0), 1'b0);

    csr_addr = 12'hB00; csr_op = 2'b01; csr_wdata = 32'hDEAD; csr_wr_en = 1'b1; csr_req = 1'b1;
    @(posedge clk); #1;
    csr_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("reset_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_done", 64'(csr_done), 64'd0);
    run(12'hB02, 2'b01, 32'h1234, 1'b1, mk(32'h10, 1'b0, 1'b0, 1'b1, 64'h0000_0002_0000_1234), 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra  = addrs[$urandom_range(0, 9)];
      rop = 2'($urandom_range(0, 3));
      rwd = $urandom;
      rwe = (rop == 2'b01) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle_in   = {$urandom, $urandom};
      instret_in = {$urandom, $urandom};
      run(ra, rop, rwd, rwe, model(ra, rop, rwd, rwe, cycle_in, instret_in), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
